// File: rtl/img_seq_pkg.sv
// Shared types and helpers for the image sequencer (img_seq_ctl, img_seq_slide_tmr).
package img_seq_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = ST_BOOT,
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } state_e;

    // Command code is {decr, incr}; both bits set behaves like "here".
    typedef logic [1:0] cmd_t;
    localparam cmd_t CMD_HERE = 2'b00;
    localparam cmd_t CMD_INC  = 2'b01;
    localparam cmd_t CMD_DEC  = 2'b10;

    // Start sector of the last image; the target when decrementing past image 0.
    function automatic logic [63:0] wrap_addr(input logic [63:0] base,
                                              input logic [63:0] step,
                                              input int unsigned num);
        return base + 64'(num - 1) * step;
    endfunction

endpackage

// File: rtl/img_seq_slide_tmr.sv
// Slideshow period counter: runs while en, clears on clr, flags the last cycle of the period.
module img_seq_slide_tmr
    import img_seq_pkg::*;
#(
    parameter int unsigned SLIDE_CYC = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (SLIDE_CYC > 1) ? $clog2(SLIDE_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLIDE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/img_seq_ctl.sv
// Picture sequencer: turns incr/decr/here commands into SD load requests.
// Optional slideshow auto-advance is enabled by defining IMG_SEQ_SLIDESHOW_EN.
module img_seq_ctl
    import img_seq_pkg::*;
#(
    parameter int unsigned NUM_IMG      = 16,
    parameter logic [31:0] IMG_BASE     = 32'd2048,
    parameter logic [31:0] SECT_PER_IMG = 32'd300,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned SLIDE_CYC    = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctl_valid,
    output logic              ctl_ready,
    input  logic              ctl_incr,
    input  logic              ctl_decr,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] ld_cnt,
    input  logic              ld_done,
    input  logic              ld_err,
    output logic [IDX_W-1:0]  cur_idx,
    output logic              busy,
    output logic              err
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IMG - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(IMG_BASE);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(SECT_PER_IMG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(wrap_addr(64'(IMG_BASE), 64'(SECT_PER_IMG), NUM_IMG));

    state_e state;
    logic   slide_exp;
    logic   accept;
    logic   go;
    cmd_t   cmd;

`ifdef IMG_SEQ_SLIDESHOW_EN
    img_seq_slide_tmr #(
        .SLIDE_CYC (SLIDE_CYC)
    ) u_slide_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    ((state != IDLE) || accept),
        .en     (state == IDLE),
        .expire (slide_exp)
    );
`else
    assign slide_exp = 1'b0;
`endif

    // On expiry the port reads not-ready unless a command is present, in which case it wins.
    assign ctl_ready = (state == IDLE) && !(slide_exp && !ctl_valid);
    assign accept    = ctl_valid && ctl_ready;
    assign go        = accept || slide_exp;
    assign cmd       = accept ? {ctl_decr, ctl_incr} : CMD_INC;

    assign ld_valid = (state == ISSUE);
    assign busy     = (state == WAIT);
    assign ld_cnt   = STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BOOT;
            cur_idx <= '0;
            ld_addr <= BASE_ADDR;
            err     <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= ISSUE;
                IDLE: begin
                    if (accept) begin
                        err <= 1'b0;
                    end
                    if (go) begin
                        case (cmd)
                            CMD_INC: begin
                                if (cur_idx == LAST_IDX) begin
                                    cur_idx <= '0;
                                    ld_addr <= BASE_ADDR;
                                end else begin
                                    cur_idx <= cur_idx + 1'b1;
                                    ld_addr <= ld_addr + STEP;
                                end
                                state <= ISSUE;
                            end
                            CMD_DEC: begin
                                if (cur_idx == '0) begin
                                    cur_idx <= LAST_IDX;
                                    ld_addr <= LAST_ADDR;
                                end else begin
                                    cur_idx <= cur_idx - 1'b1;
                                    ld_addr <= ld_addr - STEP;
                                end
                                state <= ISSUE;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    // ld_done before our own handshake belongs to a pre-reset load.
                    if (ld_ready) begin
                        if (ld_done) begin
                            state <= IDLE;
                            err   <= ld_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (ld_done) begin
                        state <= IDLE;
                        err   <= ld_err;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_img_seq_ctl.sv
// Scoreboard bench for img_seq_ctl (NUM_IMG=4, IMG_BASE=100, SECT_PER_IMG=10).
// Slideshow checks run when IMG_SEQ_SLIDESHOW_EN is defined.
module tb_img_seq_ctl;

    localparam int unsigned N    = 4;
    localparam logic [31:0] BASE = 32'd100;
    localparam logic [31:0] SECT = 32'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctl_valid = 1'b0;
    logic        ctl_incr = 1'b0;
    logic        ctl_decr = 1'b0;
    logic        ld_ready = 1'b0;
    logic        ld_done = 1'b0;
    logic        ld_err = 1'b0;
    logic        ctl_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_cnt;
    logic [1:0]  cur_idx;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] addr;
    } req_t;

    req_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_idx = 0;

    img_seq_ctl #(
        .NUM_IMG      (N),
        .IMG_BASE     (BASE),
        .SECT_PER_IMG (SECT),
        .ADDR_W       (32),
        .IDX_W        (2),
        .SLIDE_CYC    (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctl_valid (ctl_valid),
        .ctl_ready (ctl_ready),
        .ctl_incr  (ctl_incr),
        .ctl_decr  (ctl_decr),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_cnt    (ld_cnt),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .cur_idx   (cur_idx),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic req_t mk(input int idx);
        req_t r;
        r.idx  = 2'(idx);
        r.addr = BASE + 32'(idx) * SECT;
        return r;
    endfunction

    // Enter at a negedge with a request expected; leaves at the negedge after ld_done.
    task automatic serve_load(input int hold, input logic e, input logic poke);
        req_t r;
        int   n;
        n = 0;
        while (!ld_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("ld_valid_seen", ld_valid, 1);
        if (sb.size() == 0) begin
            check_val("sb_underflow", 1, 0);
            return;
        end
        r = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check_val("hold_valid", ld_valid, 1);
            check_val("hold_addr", ld_addr, r.addr);
            @(negedge clk);
        end
        check_val("ld_addr", ld_addr, r.addr);
        check_val("cur_idx", cur_idx, r.idx);
        check_val("ld_cnt", ld_cnt, SECT);
        ld_ready = 1'b1;
        @(negedge clk);
        ld_ready = 1'b0;
        check_val("wait_busy", busy, 1);
        check_val("wait_ld_valid", ld_valid, 0);
        check_val("wait_ctl_ready", ctl_ready, 0);
        if (poke) begin
            ctl_valid = 1'b1;
            ctl_incr  = 1'b1;
            @(negedge clk);
            check_val("poke_ready", ctl_ready, 0);
            ctl_valid = 1'b0;
            ctl_incr  = 1'b0;
        end
        ld_done = 1'b1;
        ld_err  = e;
        @(negedge clk);
        ld_done = 1'b0;
        ld_err  = 1'b0;
        check_val("done_ready", ctl_ready, 1);
        check_val("done_busy", busy, 0);
        check_val("done_err", err, e);
    endtask

    task automatic send_cmd(input logic inc, input logic dec);
        logic chg;
        chg = inc ^ dec;
        check_val("cmd_ready", ctl_ready, 1);
        ctl_valid = 1'b1;
        ctl_incr  = inc;
        ctl_decr  = dec;
        if (inc && !dec) begin
            m_idx = (m_idx + 1) % N;
            sb.push_back(mk(m_idx));
        end else if (dec && !inc) begin
            m_idx = (m_idx + N - 1) % N;
            sb.push_back(mk(m_idx));
        end
        @(negedge clk);
        ctl_valid = 1'b0;
        ctl_incr  = 1'b0;
        ctl_decr  = 1'b0;
        check_val("cmd_ld_valid", ld_valid, chg);
        if (!chg) check_val("here_idx", cur_idx, m_idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        req_t r;
        int   n;

        repeat (3) @(negedge clk);
        check_val("rst_ld_valid", ld_valid, 0);
        check_val("rst_ctl_ready", ctl_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err, 0);
        check_val("rst_idx", cur_idx, 0);
        check_val("rst_addr", ld_addr, BASE);
        m_idx = 0;
        sb.push_back(mk(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_val("boot_issue", ld_valid, 1);
        serve_load(0, 1'b0, 1'b0);

        // Stalled handshake, then a command offered while waiting must be ignored.
        send_cmd(1'b1, 1'b0);
        serve_load(5, 1'b0, 1'b1);
        check_val("not_consumed_idx", cur_idx, 1);
        check_val("not_consumed_valid", ld_valid, 0);

        send_cmd(1'b1, 1'b0); serve_load(0, 1'b0, 1'b0);
        send_cmd(1'b1, 1'b0); serve_load(0, 1'b0, 1'b0);
        send_cmd(1'b1, 1'b0); serve_load(0, 1'b0, 1'b0);
        send_cmd(1'b0, 1'b1); serve_load(0, 1'b0, 1'b0);
        send_cmd(1'b1, 1'b1);
        send_cmd(1'b0, 1'b0);

        send_cmd(1'b0, 1'b1);
        serve_load(0, 1'b1, 1'b0);
        send_cmd(1'b1, 1'b1);
        check_val("err_cleared", err, 0);

        // ld_done coinciding with the request handshake.
        send_cmd(1'b0, 1'b1);
        r = sb.pop_front();
        check_val("fast_addr", ld_addr, r.addr);
        check_val("fast_idx", cur_idx, r.idx);
        ld_ready = 1'b1;
        ld_done  = 1'b1;
        @(negedge clk);
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        check_val("fast_ready", ctl_ready, 1);
        check_val("fast_busy", busy, 0);

        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        check_val("idle_done_valid", ld_valid, 0);
        check_val("idle_done_idx", cur_idx, m_idx);

        // Reset during WAIT; the stale ld_done in ISSUE must not complete the new load.
        send_cmd(1'b1, 1'b0);
        r = sb.pop_front();
        check_val("mid_addr", ld_addr, r.addr);
        ld_ready = 1'b1;
        @(negedge clk);
        ld_ready = 1'b0;
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_idx", cur_idx, 0);
        check_val("mid_rst_busy", busy, 0);
        m_idx = 0;
        sb.push_back(mk(0));
        @(negedge clk);
        check_val("mid_issue", ld_valid, 1);
        ld_done = 1'b1;
        @(negedge clk);
        ld_done = 1'b0;
        check_val("stale_ignored", ld_valid, 1);
        serve_load(0, 1'b0, 1'b0);

`ifdef IMG_SEQ_SLIDESHOW_EN
        m_idx = 1;
        sb.push_back(mk(1));
        n = 0;
        while (!ld_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("slide_period", n, 20);
        serve_load(0, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        check_val("exp_ready_low", ctl_ready, 0);
        ctl_valid = 1'b1;
        ctl_decr  = 1'b1;
        #1;
        check_val("exp_ready_cmd", ctl_ready, 1);
        m_idx = 0;
        sb.push_back(mk(0));
        @(negedge clk);
        ctl_valid = 1'b0;
        ctl_decr  = 1'b0;
        check_val("exp_issue", ld_valid, 1);
        serve_load(0, 1'b0, 1'b0);
        check_val("exp_final_idx", cur_idx, 0);
`else
        repeat (30) @(negedge clk);
        check_val("no_auto_valid", ld_valid, 0);
        check_val("no_auto_idx", cur_idx, 0);
`endif

        check_val("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
